// File: rtl/usrt_pkg.sv
// rtl/usrt_pkg.sv - shared USRT framing types and constants
package usrt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int   FRAME_BITS = 11;
    localparam logic START_LVL  = 1'b0;
    localparam logic STOP_LVL   = 1'b1;

    localparam int   PAR_EVEN   = 0;
    localparam int   PAR_ODD    = 1;

endpackage

// File: rtl/usrt_rx_shift.sv
// rtl/usrt_rx_shift.sv - LSB-first serial-in shift register with enable and clear
module usrt_rx_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // New bits enter at the MSB, so the first bit received settles in bit 0.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/usrt_rx_deframer.sv
// rtl/usrt_rx_deframer.sv - receive framing FSM, parity/stop check and byte holding register
module usrt_rx_deframer
    import usrt_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = PAR_EVEN
) (
    input  logic                 pClk,
    input  logic                 pReset,
    input  logic                 baud_tick,
    input  logic                 rx_en,
    input  logic                 Tx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic                 err_parity,
    output logic                 err_frame,
    output logic                 err_overrun,
    output logic                 busy
);

    localparam int   CNT_W   = $clog2(DATA_BITS + 1);
    localparam logic PAR_LVL = (PARITY_ODD != 0);

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 par_ok_q, par_ok_d;
    logic                 shift_en;
    logic [DATA_BITS-1:0] shift_q;
    logic                 commit;
    logic                 ep_d, ef_d, eo_d;

    usrt_rx_shift #(
        .WIDTH (DATA_BITS)
    ) u_shift (
        .clk (pClk),
        .clr (pReset),
        .en  (shift_en),
        .din (Tx),
        .q   (shift_q)
    );

    // State, bit counter and latched parity verdict.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            par_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            par_ok_q <= par_ok_d;
        end
    end

    // Next state and frame outcome; everything moves only on baud ticks, except the rx_en abort.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_ok_d = par_ok_q;
        shift_en = 1'b0;
        commit   = 1'b0;
        ep_d     = 1'b0;
        ef_d     = 1'b0;
        eo_d     = 1'b0;
        if (!rx_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (Tx == START_LVL) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    par_ok_d = (((^shift_q) ^ Tx) == PAR_LVL);
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (Tx != STOP_LVL) begin
                        ef_d = 1'b1;
                    end else if (!par_ok_q) begin
                        ep_d = 1'b1;
                    end else if (out_valid && !out_ack) begin
                        eo_d = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding register: a commit beats a simultaneous ack so the new byte stays valid.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (commit) begin
            out_data  <= shift_q;
            out_valid <= 1'b1;
        end else if (out_ack) begin
            out_valid <= 1'b0;
        end
    end

    // One-cycle error pulses registered on the same edge as a commit would be.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_parity  <= ep_d;
            err_frame   <= ef_d;
            err_overrun <= eo_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_usrt_rx_deframer.sv
// tb/tb_usrt_rx_deframer.sv - scoreboard bench for usrt_rx_deframer
module tb_usrt_rx_deframer;

    localparam int K_COMMIT = 0;
    localparam int K_PAR    = 1;
    localparam int K_FRM    = 2;
    localparam int K_OVR    = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       pClk = 1'b0;
    logic       pReset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_en = 1'b0;
    logic       Tx = 1'b1;
    logic       out_ack = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, err_parity, err_frame, err_overrun, busy;
    logic [7:0] odd_data;
    logic       odd_valid, odd_err_parity, odd_err_frame, odd_err_overrun, odd_busy;

    ev_t        exp_q[$];
    int         commit_cyc[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc_cnt = 0;
    int         gap = 1;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 pClk = ~pClk;

    usrt_rx_deframer #(.DATA_BITS(8), .PARITY_ODD(0)) dut (
        .pClk(pClk), .pReset(pReset), .baud_tick(baud_tick), .rx_en(rx_en), .Tx(Tx),
        .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
        .err_parity(err_parity), .err_frame(err_frame), .err_overrun(err_overrun), .busy(busy)
    );

    usrt_rx_deframer #(.DATA_BITS(8), .PARITY_ODD(1)) dut_odd (
        .pClk(pClk), .pReset(pReset), .baud_tick(baud_tick), .rx_en(rx_en), .Tx(Tx),
        .out_data(odd_data), .out_valid(odd_valid), .out_ack(out_ack),
        .err_parity(odd_err_parity), .err_frame(odd_err_frame), .err_overrun(odd_err_overrun),
        .busy(odd_busy)
    );

    always @(posedge pClk) cyc_cnt++;

    task automatic check_ev(input int kind, input logic [7:0] d);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: got kind %0d data %02h, required no event", kind, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == K_COMMIT && e.data != d)) begin
                fails++;
                $display("FAIL event: got kind %0d data %02h, required kind %0d data %02h",
                         kind, d, e.kind, e.data);
            end
        end
    endtask

    // Monitor: turns DUT output activity into events and matches them against the queue.
    always @(negedge pClk) begin
        if (!pReset) begin
            if (out_valid && (!prev_valid || out_data != prev_data)) begin
                check_ev(K_COMMIT, out_data);
                commit_cyc.push_back(cyc_cnt);
            end
            if (err_parity)  check_ev(K_PAR, 8'h00);
            if (err_frame)   check_ev(K_FRM, 8'h00);
            if (err_overrun) check_ev(K_OVR, 8'h00);
            if (err_parity || err_frame || err_overrun) begin
                tests++;
                if ((32'(err_parity) + 32'(err_frame) + 32'(err_overrun)) > 1) begin
                    fails++;
                    $display("FAIL err_onehot: got %b%b%b, required at most one set",
                             err_parity, err_frame, err_overrun);
                end
            end
        end
        prev_valid = out_valid;
        prev_data  = out_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge pClk);
        #1;
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick_bit(input logic b, input logic ack);
        Tx = b;
        baud_tick = 1'b0;
        repeat (gap - 1) cyc();
        baud_tick = 1'b1;
        out_ack = ack;
        cyc();
        baud_tick = 1'b0;
        out_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic ack_stop);
        tick_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick_bit(d[i], 1'b0);
        tick_bit(par, 1'b0);
        tick_bit(stop, ack_stop);
        Tx = 1'b1;
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        cyc();
        out_ack = 1'b0;
    endtask

    initial begin
        int n;
        pReset = 1'b1;
        repeat (3) cyc();
        chk("reset_outputs", {out_data, out_valid, err_parity, err_frame, err_overrun, busy}, 0);
        pReset = 1'b0;
        rx_en = 1'b1;
        cyc();

        // 1: good even-parity frame, visible right after the stop-tick edge
        expect_ev(K_COMMIT, 8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        chk("a5_valid", out_valid, 1);
        chk("a5_data", out_data, 8'hA5);
        chk("odd_a5_err_parity", odd_err_parity, 1);
        do_ack();
        chk("ack_clears_valid", out_valid, 0);
        chk("ack_keeps_data", out_data, 8'hA5);

        // 2: wrong parity in even mode; the odd-mode instance accepts it
        expect_ev(K_PAR, 8'h00);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        chk("3c_no_commit", out_valid, 0);
        chk("odd_3c_valid", odd_valid, 1);
        chk("odd_3c_data", odd_data, 8'h3C);
        do_ack();

        // 3: framing error, then a good frame
        expect_ev(K_FRM, 8'h00);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        chk("81_no_commit", out_valid, 0);
        expect_ev(K_COMMIT, 8'h55);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        chk("55_data", out_data, 8'h55);
        do_ack();

        // 4: overrun keeps the held byte; ack on the stop tick is not an overrun
        expect_ev(K_COMMIT, 8'h11);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        expect_ev(K_OVR, 8'h00);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        chk("ovr_keeps_data", out_data, 8'h11);
        chk("ovr_keeps_valid", out_valid, 1);
        expect_ev(K_COMMIT, 8'h33);
        send_frame(8'h33, 1'b0, 1'b1, 1'b1);
        chk("ack_commit_data", out_data, 8'h33);
        chk("ack_commit_valid", out_valid, 1);
        do_ack();

        // 5a: abort after four data bits
        tick_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick_bit(i[0], 1'b0);
        chk("busy_midframe", busy, 1);
        rx_en = 1'b0;
        Tx = 1'b1;
        cyc();
        chk("abort_busy", busy, 0);
        rx_en = 1'b1;
        cyc();
        expect_ev(K_COMMIT, 8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("after_abort_data", out_data, 8'h5A);

        // 5b: reset mid-frame while a byte is held
        tick_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick_bit(1'b1, 1'b0);
        chk("pre_reset_valid", out_valid, 1);
        pReset = 1'b1;
        cyc();
        chk("midframe_reset", {out_data, out_valid, err_parity, err_frame, err_overrun, busy}, 0);
        pReset = 1'b0;
        Tx = 1'b1;
        cyc();

        // 6: back-to-back frames with a tick every 4 clocks
        gap = 4;
        n = commit_cyc.size();
        expect_ev(K_COMMIT, 8'hFF);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        expect_ev(K_COMMIT, 8'h00);
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        chk("b2b_data", out_data, 8'h00);
        cyc();
        chk("b2b_commits", commit_cyc.size(), n + 2);
        if (commit_cyc.size() == n + 2)
            chk("b2b_spacing", commit_cyc[n+1] - commit_cyc[n], 44);
        do_ack();

        repeat (5) cyc();
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
